pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter DRAIN_CYCLES, default 3, number of bubble cycles inserted after a HALT/FENCE leaves ID; legal range 1..7.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 id_rs1, id_rs2  input  5 each  source register indices of the instruction in ID.
REQ-005 id_use_rs1, id_use_rs2  input  1 each  the ID instruction reads the corresponding source register.
REQ-006 id_halt, id_fence  input  1 each  decoded HALT / FENCE in ID; both high together is treated as HALT.
REQ-007 ex_memread, ex_rd  input  1, 5  the load-in-EX flag and its destination register.
REQ-008 ex_redirect  input  1  taken branch, JAL or JALR resolved in EX.
REQ-009 pc_write, ifid_write  output  1 each  PC and IF/ID register enables.
REQ-010 ifid_flush, idex_flush  output  1 each  insert a bubble into IF/ID or ID/EX on the next edge.
REQ-011 halted  output  1  core is permanently stopped until reset.
REQ-012 stall_cnt, flush_cnt  output  16 each  performance counters (REQ-031).

Function
REQ-013 FSM states: RUN, DRAIN_FENCE, DRAIN_HALT, HALTED; 3-bit drain counter dcnt.
REQ-014 Load-use hazard (RUN only, combinational): ex_memread=1, ex_rd!=0, and (id_use_rs1 and id_rs1==ex_rd, or id_use_rs2 and id_rs2==ex_rd).
REQ-015 RUN, ex_redirect=1: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1; load-use and halt/fence in ID are ignored in that cycle (wrong path).
REQ-016 RUN, no redirect, load-use: pc_write=0, ifid_write=0, idex_flush=1, ifid_flush=0; stall lasts exactly one cycle because the bubble clears ex_memread.
REQ-017 RUN, no redirect, no load-use, id_halt or id_fence: pc_write=0, ifid_flush=1, idex_flush=1; next state DRAIN_HALT or DRAIN_FENCE; dcnt loaded with DRAIN_CYCLES-1.
REQ-018 Load-use takes priority over halt/fence: the halt/fence is taken on the following cycle.
REQ-019 RUN, no event: pc_write=1, ifid_write=1, both flushes 0.
REQ-020 DRAIN_*: pc_write=0, ifid_write=0, idex_flush=1, ifid_flush=0; ex_redirect and ex_memread ignored; dcnt decrements each cycle.
REQ-021 DRAIN_* with dcnt==0: DRAIN_FENCE -> RUN, DRAIN_HALT -> HALTED on the next edge.
REQ-022 Fence total latency: 1 detection cycle + DRAIN_CYCLES bubble cycles; the PC held at fence+4 resumes fetch in the first RUN cycle.
REQ-023 HALTED: pc_write=0, ifid_write=0, idex_flush=1, halted=1; the only exit is rst.
REQ-024 halted is registered and asserts on the first cycle in HALTED; it is 0 in every other state.

Reset
REQ-025 rst=1 at any edge forces state=RUN and dcnt=0, and clears both counters, including mid-drain and in HALTED.
REQ-026 Outputs in the cycle after reset: pc_write=1, ifid_write=1, flushes=0, halted=0, counters=0.
REQ-027 Reset overrides all simultaneous inputs.
REQ-028 Outputs are combinational from registered state and inputs; there is no other hidden state.

Configuration
REQ-029 Macro HAZARD_PERF_CNT_EN selects whether the performance counters are built.
REQ-030 Counters are 16 bits wide and saturate at 0xFFFF.
REQ-031 With the macro defined: stall_cnt increments on every cycle with pc_write=0 outside HALTED; flush_cnt increments on every cycle with ifid_flush=1.
REQ-032 Without the macro: stall_cnt and flush_cnt are constant 0, no counter flops are built, and all other behaviour is identical.

Verification
REQ-033 ex_memread=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle with pc_write=0, idex_flush=1; the next cycle pc_write=1.
REQ-034 Same as REQ-033 but ex_rd=0, or id_use_rs1=0 -> no stall.
REQ-035 ex_redirect=1 together with a load-use hazard and id_halt=1 -> ifid_flush=1, idex_flush=1, pc_write=1; state stays RUN.
REQ-036 id_fence=1, DRAIN_CYCLES=3 -> pc_write=0 for 4 cycles, then RUN with pc_write=1; halted=0 throughout.
REQ-037 id_halt=1 -> halted=1 on the 5th cycle after detection and stays high; rst pulse -> halted=0 and pc_write=1 on the next cycle.
REQ-038 HAZARD_PERF_CNT_EN defined, 3 load-use stalls and 2 redirects -> stall_cnt=3, flush_cnt=2; rst applied mid-drain -> counters=0 and state=RUN.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the ID/EX pipeline datapath and the hazard unit.
// master = pipeline side (drives decode/EX status), slave = hazard controller.
interface pipeline_hazard_ctrl_if;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic        id_halt;
    logic        id_fence;
    logic        ex_memread;
    logic [4:0]  ex_rd;
    logic        ex_redirect;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_flush;
    logic        halted;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_halt, id_fence,
        output ex_memread, ex_rd, ex_redirect,
        input  pc_write, ifid_write, ifid_flush, idex_flush, halted,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_halt, id_fence,
        input  ex_memread, ex_rd, ex_redirect,
        output pc_write, ifid_write, ifid_flush, idex_flush, halted,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, EX redirect flush, HALT/FENCE drain.
// Performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input logic                   clk,
    input logic                   rst,
    pipeline_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        RUN,
        DRAIN_FENCE,
        DRAIN_HALT,
        HALTED
    } state_t;

    localparam logic [2:0] DCNT_INIT = 3'(DRAIN_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] dcnt;
    logic [2:0] dcnt_nxt;
    logic       halted_q;
    logic       rs1_hit;
    logic       rs2_hit;
    logic       load_use;
    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_flush;

    assign rs1_hit  = hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd);
    assign rs2_hit  = hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd);
    assign load_use = hz.ex_memread && (hz.ex_rd != '0) && (rs1_hit || rs2_hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            dcnt     <= '0;
            halted_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            dcnt     <= dcnt_nxt;
            halted_q <= (state_nxt == HALTED);
        end
    end

    // Priority in RUN: redirect (wrong-path ID) > load-use > halt/fence.
    always_comb begin
        state_nxt  = state;
        dcnt_nxt   = dcnt;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        case (state)
            RUN: begin
                if (hz.ex_redirect) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (load_use) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                end else if (hz.id_halt || hz.id_fence) begin
                    pc_write   = 1'b0;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    dcnt_nxt   = DCNT_INIT;
                    state_nxt  = hz.id_halt ? DRAIN_HALT : DRAIN_FENCE;
                end
            end
            DRAIN_FENCE, DRAIN_HALT: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
                if (dcnt == '0) begin
                    state_nxt = (state == DRAIN_HALT) ? HALTED : RUN;
                end else begin
                    dcnt_nxt = dcnt - 3'd1;
                end
            end
            HALTED: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    assign hz.pc_write   = pc_write;
    assign hz.ifid_write = ifid_write;
    assign hz.ifid_flush = ifid_flush;
    assign hz.idex_flush = idex_flush;
    assign hz.halted     = halted_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_q;
    logic [15:0] flush_q;

    // Saturating counters; cycles spent in HALTED are not stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_write && (state != HALTED) && (stall_q != '1)) begin
                stall_q <= stall_q + 16'd1;
            end
            if (ifid_flush && (flush_q != '1)) begin
                flush_q <= flush_q + 16'd1;
            end
        end
    end

    assign hz.stall_cnt = stall_q;
    assign hz.flush_cnt = flush_q;
`else
    assign hz.stall_cnt = '0;
    assign hz.flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (DRAIN_CYCLES=3); counter expectations
// follow HAZARD_PERF_CNT_EN.
module tb_pipeline_hazard_ctrl;
    localparam int unsigned DRAIN = 3;

    // {pc_write, ifid_write, ifid_flush, idex_flush, halted}
    localparam logic [4:0] RUNV   = 5'b11000;
    localparam logic [4:0] STALLV = 5'b00010;
    localparam logic [4:0] REDIRV = 5'b11110;
    localparam logic [4:0] DETV   = 5'b01110;
    localparam logic [4:0] DRAINV = 5'b00010;
    localparam logic [4:0] HALTV  = 5'b00011;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic       memread;
        logic [4:0] rd;
        logic       redirect;
        logic       halt;
        logic       fence;
        logic [4:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  sb[$];
    int          checks = 0;
    int          fails = 0;
    logic [15:0] m_stall;
    logic [15:0] m_flush;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if bus ();

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (bus)
    );

    function automatic vec_t vec(input logic [4:0] rs1, input logic u1,
                                 input logic [4:0] rs2, input logic u2,
                                 input logic memread, input logic [4:0] rd,
                                 input logic redirect, input logic halt,
                                 input logic fence, input logic [4:0] exp);
        vec_t t;
        t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2;
        t.memread = memread; t.rd = rd; t.redirect = redirect;
        t.halt = halt; t.fence = fence; t.exp = exp;
        return t;
    endfunction

    function automatic vec_t idle(input logic [4:0] exp);
        return vec(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, exp);
    endfunction

    function automatic logic [4:0] ctl();
        return {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_flush, bus.halted};
    endfunction

    task automatic apply(input vec_t t);
        bus.id_rs1      = t.rs1;
        bus.id_use_rs1  = t.u1;
        bus.id_rs2      = t.rs2;
        bus.id_use_rs2  = t.u2;
        bus.ex_memread  = t.memread;
        bus.ex_rd       = t.rd;
        bus.ex_redirect = t.redirect;
        bus.id_halt     = t.halt;
        bus.id_fence    = t.fence;
        sb.push_back(t.exp);
    endtask

    task automatic drive_idle();
        bus.id_rs1 = '0; bus.id_use_rs1 = 1'b0; bus.id_rs2 = '0; bus.id_use_rs2 = 1'b0;
        bus.ex_memread = 1'b0; bus.ex_rd = '0; bus.ex_redirect = 1'b0;
        bus.id_halt = 1'b0; bus.id_fence = 1'b0;
    endtask

    // Reference counter model driven by the expected control vector of each cycle.
    task automatic account(input logic [4:0] e);
        if (!e[4] && !e[0] && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
        if (e[2] && m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_stall = '0;
        m_flush = '0;
    endtask

    task automatic test_reset();
        logic [4:0] got, want;
        rst = 1'b1;
        apply(vec(5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, RUNV));
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        m_stall = '0;
        m_flush = '0;
        drive_idle();
        @(negedge clk);
        got  = ctl();
        want = sb.pop_front();
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL reset_ctl: got %b want %b", got, want);
        end
        checks++;
        if (bus.stall_cnt !== 16'd0 || bus.flush_cnt !== 16'd0) begin
            fails++;
            $display("FAIL reset_cnt: got stall=%0d flush=%0d want 0/0", bus.stall_cnt, bus.flush_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_load_use();
        vec_t q[$];
        logic [4:0] got, want;
        q.push_back(vec(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, STALLV));
        q.push_back(idle(RUNV));
        q.push_back(vec(5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, STALLV));
        q.push_back(idle(RUNV));
        q.push_back(vec(5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, RUNV));
        q.push_back(vec(5'd5, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, RUNV));
        q.push_back(vec(5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, RUNV));
        q.push_back(vec(5'd5, 1'b1, 5'd6, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, RUNV));
        q.push_back(vec(5'd3, 1'b1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, RUNV));
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clk);
            got  = ctl();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL load_use[%0d]: got %b want %b", i, got, want);
            end
            account(want);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect();
        vec_t q[$];
        logic [4:0] got, want;
        q.push_back(vec(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, REDIRV));
        q.push_back(idle(RUNV));
        q.push_back(vec(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, REDIRV));
        q.push_back(idle(RUNV));
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clk);
            got  = ctl();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL redirect[%0d]: got %b want %b", i, got, want);
            end
            account(want);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fence();
        vec_t q[$];
        logic [4:0] got, want;
        q.push_back(vec(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, DETV));
        q.push_back(vec(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, DRAINV));
        q.push_back(vec(5'd4, 1'b1, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, DRAINV));
        q.push_back(idle(DRAINV));
        q.push_back(idle(RUNV));
        q.push_back(idle(RUNV));
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clk);
            got  = ctl();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL fence[%0d]: got %b want %b", i, got, want);
            end
            account(want);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        vec_t q[$];
        logic [4:0] got, want;
        q.push_back(vec(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, REDIRV));
        q.push_back(vec(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, REDIRV));
        q.push_back(vec(5'd8, 1'b1, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, STALLV));
        q.push_back(vec(5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, STALLV));
        q.push_back(idle(RUNV));
        q.push_back(vec(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, STALLV));
        q.push_back(vec(5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b1, DETV));
        q.push_back(idle(DRAINV));
        q.push_back(idle(DRAINV));
        q.push_back(idle(DRAINV));
        q.push_back(idle(RUNV));
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clk);
            got  = ctl();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL back_to_back[%0d]: got %b want %b", i, got, want);
            end
            account(want);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_halt();
        vec_t q[$];
        logic [4:0] got, want;
        q.push_back(vec(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, DETV));
        q.push_back(idle(DRAINV));
        q.push_back(idle(DRAINV));
        q.push_back(idle(DRAINV));
        q.push_back(idle(HALTV));
        q.push_back(vec(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, HALTV));
        q.push_back(vec(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, HALTV));
        q.push_back(vec(5'd6, 1'b1, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, HALTV));
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clk);
            got  = ctl();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL halt[%0d]: got %b want %b", i, got, want);
            end
            account(want);
            @(posedge clk); #1;
        end
        do_reset();
        apply(idle(RUNV));
        @(negedge clk);
        got  = ctl();
        want = sb.pop_front();
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL halt_exit_reset: got %b want %b", got, want);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_counters();
        vec_t q[$];
        logic [4:0]  got, want;
        logic [15:0] es, ef;
        do_reset();
        for (int unsigned k = 0; k < 3; k++) begin
            q.push_back(vec(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, STALLV));
            q.push_back(idle(RUNV));
        end
        for (int unsigned k = 0; k < 2; k++) begin
            q.push_back(vec(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, REDIRV));
            q.push_back(idle(RUNV));
        end
        foreach (q[i]) begin
            apply(q[i]);
            @(negedge clk);
            got  = ctl();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL counters_seq[%0d]: got %b want %b", i, got, want);
            end
            account(want);
            @(posedge clk); #1;
        end
        drive_idle();
        @(negedge clk);
        es = PERF ? m_stall : 16'd0;
        ef = PERF ? m_flush : 16'd0;
        checks++;
        if (bus.stall_cnt !== es || bus.flush_cnt !== ef) begin
            fails++;
            $display("FAIL counters_3_2: got stall=%0d flush=%0d want %0d/%0d",
                     bus.stall_cnt, bus.flush_cnt, es, ef);
        end
        @(posedge clk); #1;

        // Enter a fence drain, then reset two cycles into it.
        apply(vec(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, DETV));
        @(negedge clk);
        got  = ctl();
        want = sb.pop_front();
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL middrain_detect: got %b want %b", got, want);
        end
        @(posedge clk); #1;
        drive_idle();
        do_reset();
        apply(idle(RUNV));
        @(negedge clk);
        got  = ctl();
        want = sb.pop_front();
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL middrain_reset_ctl: got %b want %b", got, want);
        end
        checks++;
        if (bus.stall_cnt !== 16'd0 || bus.flush_cnt !== 16'd0) begin
            fails++;
            $display("FAIL middrain_reset_cnt: got stall=%0d flush=%0d want 0/0",
                     bus.stall_cnt, bus.flush_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        logic [15:0] es;
        do_reset();
        bus.id_rs1 = 5'd5; bus.id_use_rs1 = 1'b1; bus.ex_memread = 1'b1; bus.ex_rd = 5'd5;
        repeat (65540) @(posedge clk);
        #1;
        drive_idle();
        @(negedge clk);
        es = PERF ? 16'hFFFF : 16'd0;
        checks++;
        if (bus.stall_cnt !== es || bus.flush_cnt !== 16'd0) begin
            fails++;
            $display("FAIL stall_saturate: got stall=%0d flush=%0d want %0d/0",
                     bus.stall_cnt, bus.flush_cnt, es);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        m_stall = '0;
        m_flush = '0;
        drive_idle();
        #1;
        test_reset();
        test_load_use();
        test_redirect();
        test_fence();
        test_back_to_back();
        test_halt();
        test_counters();
        test_saturation();
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
